// File: rtl/fp16_align_add.sv
`timescale 1ns/1ps
// fp16_align_add: two-stage alignment and mantissa add/subtract front end.
// Stage 1 unpacks, orders by magnitude, aligns the smaller mantissa and
// classifies specials; stage 2 adds or subtracts and presents the raw result.
module fp16_align_add #(
  parameter bit FLUSH_ZERO = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        in_sub,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        out_ready,
  output logic        out_valid,
  output logic        out_sign,
  output logic [4:0]  out_exp,
  output logic [11:0] out_mant,
  output logic [1:0]  out_exc
);

  localparam logic [1:0] EXC_FINITE = 2'b00;
  localparam logic [1:0] EXC_INF    = 2'b01;
  localparam logic [1:0] EXC_NAN    = 2'b10;

  // Operand fields; B's sign is flipped for subtraction so the rest of the
  // datapath only ever sees an addition of signed magnitudes.
  logic       sign_a, sign_b;
  logic [4:0] exp_a, exp_b;
  logic [9:0] frac_a, frac_b;
  logic [9:0] frac_use_a, frac_use_b;
  logic [10:0] mant_a, mant_b;
  logic [4:0] eff_a, eff_b;
  logic       nan_a, nan_b, inf_a, inf_b;
  logic       eff_sub;
  logic       a_ge_b;

  assign sign_a = in_a[15];
  assign sign_b = in_b[15] ^ in_sub;
  assign exp_a  = in_a[14:10];
  assign exp_b  = in_b[14:10];
  assign frac_a = in_a[9:0];
  assign frac_b = in_b[9:0];

  assign nan_a = (exp_a == 5'd31) && (frac_a != 10'd0);
  assign nan_b = (exp_b == 5'd31) && (frac_b != 10'd0);
  assign inf_a = (exp_a == 5'd31) && (frac_a == 10'd0);
  assign inf_b = (exp_b == 5'd31) && (frac_b == 10'd0);

  // Flushed subnormals behave as zero both in the compare and the sum.
  assign frac_use_a = (FLUSH_ZERO && (exp_a == 5'd0)) ? 10'd0 : frac_a;
  assign frac_use_b = (FLUSH_ZERO && (exp_b == 5'd0)) ? 10'd0 : frac_b;

  assign mant_a = {(exp_a != 5'd0), frac_use_a};
  assign mant_b = {(exp_b != 5'd0), frac_use_b};
  assign eff_a  = (exp_a == 5'd0) ? 5'd1 : exp_a;
  assign eff_b  = (exp_b == 5'd0) ? 5'd1 : exp_b;

  assign eff_sub = sign_a ^ sign_b;
  assign a_ge_b  = {exp_a, frac_use_a} >= {exp_b, frac_use_b};

  // Stage 1 datapath: pick the larger operand, align the smaller one and
  // decide whether the result is a special value.
  logic        l_sign;
  logic [4:0]  l_exp, l_eff, s_eff;
  logic [10:0] l_mant, s_mant;
  logic [4:0]  shift;
  logic [10:0] s_aligned;
  logic [1:0]  exc_next;
  logic        sign_next;
  logic [4:0]  exp_next;

  always_comb begin
    l_sign = sign_a;
    l_exp  = exp_a;
    l_eff  = eff_a;
    l_mant = mant_a;
    s_eff  = eff_b;
    s_mant = mant_b;
    if (!a_ge_b) begin
      l_sign = sign_b;
      l_exp  = exp_b;
      l_eff  = eff_b;
      l_mant = mant_b;
      s_eff  = eff_a;
      s_mant = mant_a;
    end
    shift     = l_eff - s_eff;
    s_aligned = (shift >= 5'd11) ? 11'd0 : (s_mant >> shift);

    exc_next  = EXC_FINITE;
    sign_next = l_sign;
    exp_next  = l_exp;
    if (nan_a || nan_b || (inf_a && inf_b && eff_sub)) begin
      exc_next  = EXC_NAN;
      sign_next = 1'b0;
      exp_next  = 5'd31;
    end else if (inf_a) begin
      exc_next  = EXC_INF;
      sign_next = sign_a;
      exp_next  = 5'd31;
    end else if (inf_b) begin
      exc_next  = EXC_INF;
      sign_next = sign_b;
      exp_next  = 5'd31;
    end
  end

  // Pipeline control: stage 2 refills when empty or draining, stage 1
  // accepts whenever it is empty or moving forward.
  logic s1_valid, s2_valid;
  logic s2_load;

  assign s2_load   = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_load;
  assign out_valid = s2_valid;

  logic        s1_sign, s1_sub;
  logic [4:0]  s1_exp;
  logic [10:0] s1_ml, s1_ms;
  logic [1:0]  s1_exc;

  // Stage 1 register: holds the ordered, aligned operand pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_sub   <= 1'b0;
      s1_exp   <= 5'd0;
      s1_ml    <= 11'd0;
      s1_ms    <= 11'd0;
      s1_exc   <= EXC_FINITE;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= sign_next;
        s1_sub  <= eff_sub;
        s1_exp  <= exp_next;
        s1_ml   <= l_mant;
        s1_ms   <= s_aligned;
        s1_exc  <= exc_next;
      end
    end
  end

  // Stage 2 datapath: unsigned add or subtract; L >= S keeps it non-negative.
  logic [11:0] sum;
  logic [11:0] mant_next;
  logic        sign_out_next;

  always_comb begin
    sum = s1_sub ? ({1'b0, s1_ml} - {1'b0, s1_ms})
                 : ({1'b0, s1_ml} + {1'b0, s1_ms});
    mant_next     = sum;
    sign_out_next = s1_sign;
    if (s1_exc == EXC_NAN) begin
      mant_next = 12'h200;
    end else if (s1_exc == EXC_INF) begin
      mant_next = 12'h000;
    end else if (s1_sub && (sum == 12'd0)) begin
      sign_out_next = 1'b0;
    end
  end

  // Stage 2 register: output holding register, frozen while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_sign <= 1'b0;
      out_exp  <= 5'd0;
      out_mant <= 12'd0;
      out_exc  <= EXC_FINITE;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_sign <= sign_out_next;
        out_exp  <= s1_exp;
        out_mant <= mant_next;
        out_exc  <= s1_exc;
      end
    end
  end

endmodule

// File: tb/tb_fp16_align_add.sv
`timescale 1ns/1ps
// Testbench for fp16_align_add: both FLUSH_ZERO settings run side by side on
// shared inputs; a scoreboard checks every output beat against a model.
module tb_fp16_align_add;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_a = 16'h0;
  logic [15:0] in_b = 16'h0;
  logic        in_sub = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready0, out_valid0, out_sign0;
  logic [4:0]  out_exp0;
  logic [11:0] out_mant0;
  logic [1:0]  out_exc0;
  logic        in_ready1, out_valid1, out_sign1;
  logic [4:0]  out_exp1;
  logic [11:0] out_mant1;
  logic [1:0]  out_exc1;

  int n_checks = 0;
  int n_pass = 0;
  logic [19:0] exp_q0[$];
  logic [19:0] exp_q1[$];
  bit bp_done = 1'b0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [19:0] e0;
    logic [19:0] e1;
  } vec_t;
  vec_t vecs[$];

  fp16_align_add #(.FLUSH_ZERO(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .in_valid(in_valid), .in_ready(in_ready0), .out_ready(out_ready),
    .out_valid(out_valid0), .out_sign(out_sign0), .out_exp(out_exp0),
    .out_mant(out_mant0), .out_exc(out_exc0)
  );

  fp16_align_add #(.FLUSH_ZERO(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .in_valid(in_valid), .in_ready(in_ready1), .out_ready(out_ready),
    .out_valid(out_valid1), .out_sign(out_sign1), .out_exp(out_exp1),
    .out_mant(out_mant1), .out_exc(out_exc1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference result packed as {sign, exp[4:0], mant[11:0], exc[1:0]}.
  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic sub, input bit fz);
    int ea, eb, fa, fb, ka, kb, el, es, ml, ms, d, m;
    bit sa, sb, sl, so;
    logic [4:0]  eo;
    logic [11:0] mo;
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    fa = int'(a[9:0]);
    fb = int'(b[9:0]);
    sa = a[15];
    sb = b[15] ^ sub;
    if (ea == 31 && fa != 0 || eb == 31 && fb != 0 ||
        ea == 31 && eb == 31 && fa == 0 && fb == 0 && sa != sb)
      return {1'b0, 5'd31, 12'h200, 2'b10};
    if (ea == 31) return {sa, 5'd31, 12'h000, 2'b01};
    if (eb == 31) return {sb, 5'd31, 12'h000, 2'b01};
    if (fz && ea == 0) fa = 0;
    if (fz && eb == 0) fb = 0;
    ka = ea * 1024 + fa;
    kb = eb * 1024 + fb;
    if (ka >= kb) begin
      el = ea; es = eb; sl = sa;
      ml = (ea != 0) ? 1024 + fa : fa;
      ms = (eb != 0) ? 1024 + fb : fb;
    end else begin
      el = eb; es = ea; sl = sb;
      ml = (eb != 0) ? 1024 + fb : fb;
      ms = (ea != 0) ? 1024 + fa : fa;
    end
    d = ((el == 0) ? 1 : el) - ((es == 0) ? 1 : es);
    ms = (d >= 11) ? 0 : (ms >> d);
    m = (sa == sb) ? ml + ms : ml - ms;
    so = (sa != sb && m == 0) ? 1'b0 : sl;
    eo = el[4:0];
    mo = m[11:0];
    return {so, eo, mo, 2'b00};
  endfunction

  task automatic checkOutput(input string tag, input logic [19:0] observed,
                             input logic [19:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  // Scoreboard: push on accepted input, compare head while valid, pop on transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready0) exp_q0.push_back(model(in_a, in_b, in_sub, 1'b0));
      if (in_valid && in_ready1) exp_q1.push_back(model(in_a, in_b, in_sub, 1'b1));
      if (out_valid0) begin
        if (exp_q0.size() == 0) checkOutput("spurious_out_fz0", 20'(out_valid0), 20'd0);
        else begin
          checkOutput("sb_result_fz0", {out_sign0, out_exp0, out_mant0, out_exc0}, exp_q0[0]);
          if (out_ready) void'(exp_q0.pop_front());
        end
      end
      if (out_valid1) begin
        if (exp_q1.size() == 0) checkOutput("spurious_out_fz1", 20'(out_valid1), 20'd0);
        else begin
          checkOutput("sb_result_fz1", {out_sign1, out_exp1, out_mant1, out_exc1}, exp_q1[0]);
          if (out_ready) void'(exp_q1.pop_front());
        end
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic sub);
    bit done;
    done = 1'b0;
    in_a = a;
    in_b = b;
    in_sub = sub;
    in_valid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (in_ready0) done = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) checkOutput("accept_timeout", 20'(done), 20'd1);
  endtask

  task automatic drainAll();
    int i;
    i = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && i < 100) begin
      @(posedge clk);
      #1;
      i++;
    end
    checkOutput("drain_empty", 20'(exp_q0.size() + exp_q1.size()), 20'd0);
  endtask

  initial begin
    vecs.push_back('{16'h3C00, 16'h3C00, 1'b0, {1'b0, 5'd15, 12'h800, 2'b00}, {1'b0, 5'd15, 12'h800, 2'b00}});
    vecs.push_back('{16'h3C00, 16'h4000, 1'b1, {1'b1, 5'd16, 12'h200, 2'b00}, {1'b1, 5'd16, 12'h200, 2'b00}});
    vecs.push_back('{16'h3C00, 16'h3C00, 1'b1, {1'b0, 5'd15, 12'h000, 2'b00}, {1'b0, 5'd15, 12'h000, 2'b00}});
    vecs.push_back('{16'h7BFF, 16'h3C00, 1'b0, {1'b0, 5'd30, 12'h7FF, 2'b00}, {1'b0, 5'd30, 12'h7FF, 2'b00}});
    vecs.push_back('{16'h4000, 16'h3C00, 1'b0, {1'b0, 5'd16, 12'h600, 2'b00}, {1'b0, 5'd16, 12'h600, 2'b00}});
    vecs.push_back('{16'h0001, 16'h0001, 1'b0, {1'b0, 5'd0, 12'h002, 2'b00}, {1'b0, 5'd0, 12'h000, 2'b00}});
    vecs.push_back('{16'h7C00, 16'h7C00, 1'b1, {1'b0, 5'd31, 12'h200, 2'b10}, {1'b0, 5'd31, 12'h200, 2'b10}});
    vecs.push_back('{16'hFC00, 16'h3C00, 1'b0, {1'b1, 5'd31, 12'h000, 2'b01}, {1'b1, 5'd31, 12'h000, 2'b01}});
    vecs.push_back('{16'h7E00, 16'h3C00, 1'b0, {1'b0, 5'd31, 12'h200, 2'b10}, {1'b0, 5'd31, 12'h200, 2'b10}});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, {1'b1, 5'd0, 12'h000, 2'b00}, {1'b1, 5'd0, 12'h000, 2'b00}});
    vecs.push_back('{16'h8001, 16'h0003, 1'b1, {1'b1, 5'd0, 12'h004, 2'b00}, {1'b1, 5'd0, 12'h000, 2'b00}});
    vecs.push_back('{16'h3C00, 16'hBC00, 1'b0, {1'b0, 5'd15, 12'h000, 2'b00}, {1'b0, 5'd15, 12'h000, 2'b00}});

    // Reset state
    #2;
    checkOutput("reset_valid_fz0", 20'(out_valid0), 20'd0);
    checkOutput("reset_valid_fz1", 20'(out_valid1), 20'd0);
    checkOutput("reset_outs", {out_sign0, out_exp0, out_mant0, out_exc0}, 20'd0);
    checkOutput("reset_in_ready", 20'(in_ready0), 20'd1);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Directed single ops with exact two-cycle latency
    foreach (vecs[k]) begin
      applyStimulus(vecs[k].a, vecs[k].b, vecs[k].sub);
      checkOutput($sformatf("lat_s1_%0d", k), 20'(out_valid0), 20'd0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("lat_s2_%0d", k), 20'(out_valid0), 20'd1);
      checkOutput($sformatf("vec%0d_fz0", k), {out_sign0, out_exp0, out_mant0, out_exc0}, vecs[k].e0);
      checkOutput($sformatf("vec%0d_fz1", k), {out_sign1, out_exp1, out_mant1, out_exc1}, vecs[k].e1);
    end
    drainAll();

    // Back-to-back stream, including random operands
    foreach (vecs[k]) applyStimulus(vecs[k].a, vecs[k].b, vecs[k].sub);
    for (int i = 0; i < 24; i++)
      applyStimulus(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    drainAll();

    // Backpressure: four ops while the output is stalled
    out_ready = 1'b0;
    fork
      begin
        applyStimulus(16'h3C00, 16'h3C00, 1'b0);
        applyStimulus(16'h4000, 16'h3C00, 1'b0);
        applyStimulus(16'h3C00, 16'h4000, 1'b1);
        applyStimulus(16'h7BFF, 16'h3C00, 1'b0);
        bp_done = 1'b1;
      end
    join_none
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("bp_in_ready_low", 20'(in_ready0), 20'd0);
    checkOutput("bp_out_valid", 20'(out_valid0), 20'd1);
    checkOutput("bp_head_held", {out_sign0, out_exp0, out_mant0, out_exc0}, {1'b0, 5'd15, 12'h800, 2'b00});
    repeat (3) @(negedge clk);
    checkOutput("bp_still_held", {out_sign0, out_exp0, out_mant0, out_exc0}, {1'b0, 5'd15, 12'h800, 2'b00});
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && !bp_done; i++) @(posedge clk);
    #1;
    checkOutput("bp_sends_done", 20'(bp_done), 20'd1);
    drainAll();

    // Asynchronous reset with both stages full
    out_ready = 1'b0;
    applyStimulus(16'h3C00, 16'h3C00, 1'b0);
    applyStimulus(16'h4000, 16'h3C00, 1'b0);
    #3;
    rst_n = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    #1;
    checkOutput("rst_async_valid_fz0", 20'(out_valid0), 20'd0);
    checkOutput("rst_async_valid_fz1", 20'(out_valid1), 20'd0);
    checkOutput("rst_async_outs", {out_sign0, out_exp0, out_mant0, out_exc0}, 20'd0);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_no_replay", 20'(out_valid0), 20'd0);
    applyStimulus(16'h4000, 16'h3C00, 1'b0);
    checkOutput("rst_lat_s1", 20'(out_valid0), 20'd0);
    @(posedge clk);
    #1;
    checkOutput("rst_lat_s2", 20'(out_valid0), 20'd1);
    checkOutput("rst_first_result", {out_sign0, out_exp0, out_mant0, out_exc0}, {1'b0, 5'd16, 12'h600, 2'b00});
    drainAll();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
